// File: rtl/decoder_seq.sv
// Registered N-to-2^N one-hot decoder with LATCH, PULSE and SCAN modes.
// Every output is driven straight from a flop; Y polarity is set by ACTIVE_LOW.
module decoder_seq #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    A,
    input  logic            E,
    input  logic [1:0]      mode,
    output logic [2**N-1:0] Y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  SIDX_TOP = '1;
    localparam logic [W-1:0]  POL_MASK = {W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        M_LATCH = 2'b00,
        M_PULSE = 2'b01,
        M_SCAN  = 2'b10,
        M_RSVD  = 2'b11
    } mode_e;

    logic          r_e_q;
    mode_e         r_mode_q;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_sidx;
    logic          r_top;
    logic [W-1:0]  r_y;
    logic [N-1:0]  r_idx;
    logic          r_wrap;

    mode_e         w_mode;
    logic [CW-1:0] w_cnt;
    logic [N-1:0]  w_sidx;
    logic          w_top;
    logic [W-1:0]  w_y;
    logic [N-1:0]  w_idx;
    logic          w_wrap;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
        logic [W-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    assign w_mode = mode_e'(mode);

    always_comb begin
        w_y    = '0;
        w_idx  = r_idx;
        w_wrap = 1'b0;
        w_cnt  = r_cnt;
        w_sidx = r_sidx;
        w_top  = r_top;

        if (w_mode != r_mode_q) begin
            // A mode change only clears state; a coincident E edge is consumed.
            w_cnt  = '0;
            w_sidx = '0;
            w_top  = 1'b0;
        end else begin
            case (w_mode)
                M_LATCH: begin
                    if (E) begin
                        w_y   = onehot(A);
                        w_idx = A;
                    end
                end
                M_PULSE: begin
                    if (E && !r_e_q) begin
                        w_y   = onehot(A);
                        w_idx = A;
                    end
                end
                M_SCAN: begin
                    if (E) begin
                        w_y    = onehot(r_sidx);
                        w_idx  = r_sidx;
                        // r_top remembers that channel 0 is being re-entered from the top.
                        w_wrap = (r_sidx == '0) && r_top;
                        if (r_sidx == '0)
                            w_top = 1'b0;
                        if (r_cnt == CNT_LAST) begin
                            w_cnt  = '0;
                            w_sidx = r_sidx + 1'b1;
                            if (r_sidx == SIDX_TOP)
                                w_top = 1'b1;
                        end else begin
                            w_cnt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_q    <= 1'b0;
            r_mode_q <= M_LATCH;
            r_cnt    <= '0;
            r_sidx   <= '0;
            r_top    <= 1'b0;
            r_y      <= POL_MASK;
            r_idx    <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_e_q    <= E;
            r_mode_q <= w_mode;
            r_cnt    <= w_cnt;
            r_sidx   <= w_sidx;
            r_top    <= w_top;
            r_y      <= w_y ^ POL_MASK;
            r_idx    <= w_idx;
            r_wrap   <= w_wrap;
        end
    end

    assign Y    = r_y;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: four instances cover default, active-low,
// small-N/DWELL=2 scan and the DWELL=1 boundary, all sharing one stimulus.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       E;
    logic [1:0] mode;
    logic [2:0] a3;
    logic [1:0] a2;
    logic       a1;

    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1;
    logic [3:0] y2;
    logic [1:0] idx2;
    logic       wrap2;
    logic [1:0] y3;
    logic       idx3;
    logic       wrap3;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    assign a2 = a3[1:0];
    assign a1 = a3[0];

    always #5 clk = ~clk;

    decoder_seq #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .A(a3), .E(E), .mode(mode),
        .Y(y0), .idx(idx0), .wrap(wrap0)
    );
    decoder_seq #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a3), .E(E), .mode(mode),
        .Y(y1), .idx(idx1), .wrap(wrap1)
    );
    decoder_seq #(.N(2), .DWELL(2), .ACTIVE_LOW(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .A(a2), .E(E), .mode(mode),
        .Y(y2), .idx(idx2), .wrap(wrap2)
    );
    decoder_seq #(.N(1), .DWELL(1), .ACTIVE_LOW(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .A(a1), .E(E), .mode(mode),
        .Y(y3), .idx(idx3), .wrap(wrap3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned exp_ch2 [18] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3,0,0};
    int unsigned scan_after [4] = '{0,0,1,1};

    initial begin
        rst = 1'b1; E = 1'b1; a3 = 3'd7; mode = 2'b00;

        // Reset
        tick(); tick();
        check("rst_y",     64'(y0),    64'h00);
        check("rst_idx",   64'(idx0),  64'h0);
        check("rst_wrap",  64'(wrap0), 64'h0);
        check("rst_y_al",  64'(y1),    64'hFF);

        // LATCH
        rst = 1'b0; E = 1'b1; a3 = 3'd5;
        tick();
        check("latch_a5_y",   64'(y0),   64'h20);
        check("latch_a5_idx", 64'(idx0), 64'h5);
        check("latch_a5_yal", 64'(y1),   64'hDF);
        a3 = 3'd0;
        tick();
        check("latch_a0_y",   64'(y0),   64'h01);
        check("latch_a0_idx", 64'(idx0), 64'h0);
        E = 1'b0;
        tick();
        check("latch_e0_y",   64'(y0),   64'h00);
        check("latch_e0_idx", 64'(idx0), 64'h0);
        E = 1'b1; a3 = 3'd5;
        tick();
        E = 1'b0;
        tick();
        check("latch_hold_y",   64'(y0),   64'h00);
        check("latch_hold_idx", 64'(idx0), 64'h5);

        // PULSE
        mode = 2'b01;
        tick();
        check("pulse_entry_y", 64'(y0), 64'h00);
        E = 1'b1; a3 = 3'd3;
        tick();
        check("pulse_a3_y",   64'(y0),   64'h08);
        check("pulse_a3_idx", 64'(idx0), 64'h3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("pulse_hold_y%0d", i), 64'(y0), 64'h00);
        end
        E = 1'b0;
        tick();
        check("pulse_low_y", 64'(y0), 64'h00);
        E = 1'b1; a3 = 3'd6;
        tick();
        check("pulse_a6_y",   64'(y0),   64'h40);
        check("pulse_a6_idx", 64'(idx0), 64'h6);
        check("pulse_a6_yal", 64'(y1),   64'hBF);
        tick();
        check("pulse_a6_end", 64'(y0), 64'h00);

        // Rising E coincident with a change into PULSE is consumed
        mode = 2'b00; E = 1'b0;
        tick(); tick();
        mode = 2'b01; E = 1'b1; a3 = 3'd2;
        tick();
        check("pulse_chg_edge_y", 64'(y0), 64'h00);
        tick();
        check("pulse_chg_next_y", 64'(y0), 64'h00);

        // SCAN entry, then 18 enabled cycles
        mode = 2'b10; E = 1'b0;
        tick();
        check("scan_entry_y2", 64'(y2), 64'h0);
        E = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick();
            check($sformatf("scan2_y_%0d", k),    64'(y2),    64'(4'(1) << exp_ch2[k]));
            check($sformatf("scan2_idx_%0d", k),  64'(idx2),  64'(exp_ch2[k]));
            check($sformatf("scan2_wrap_%0d", k), 64'(wrap2), 64'((k == 8 || k == 16) ? 1 : 0));
            check($sformatf("scan0_y_%0d", k),    64'(y0),    64'(8'(1) << ((k / 4) % 8)));
            check($sformatf("scan0_wrap_%0d", k), 64'(wrap0), 64'h0);
            check($sformatf("scan3_y_%0d", k),    64'(y3),    64'(2'(1) << (k % 2)));
            check($sformatf("scan3_wrap_%0d", k), 64'(wrap3), 64'((k >= 2 && k % 2 == 0) ? 1 : 0));
        end

        // Pause after first cycle of channel 1
        tick();
        check("pause_pre_y2", 64'(y2), 64'h2);
        E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("pause_y2_%0d", i), 64'(y2), 64'h0);
        end
        E = 1'b1;
        tick();
        check("resume_ch1_y2", 64'(y2), 64'h2);
        tick();
        check("resume_ch2a_y2", 64'(y2), 64'h4);
        tick();
        check("resume_ch2b_y2", 64'(y2),    64'h4);
        check("resume_wrap2",   64'(wrap2), 64'h0);

        // SCAN -> LATCH -> SCAN
        mode = 2'b00; a3 = 3'd1;
        tick();
        check("chg_latch_y2",   64'(y2),   64'h0);
        check("chg_latch_idx2", 64'(idx2), 64'h2);
        mode = 2'b10;
        tick();
        check("chg_scan_y2", 64'(y2), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rescan_y2_%0d", k), 64'(y2), 64'(4'(1) << scan_after[k]));
        end

        // Reset mid-scan
        tick();
        rst = 1'b1;
        tick();
        check("midrst_y2",   64'(y2),   64'h0);
        check("midrst_idx2", 64'(idx2), 64'h0);
        check("midrst_y1",   64'(y1),   64'hFF);
        mode = 2'b00;
        tick();
        rst = 1'b0; E = 1'b0;
        tick();
        check("postrst_latch_y2", 64'(y2), 64'h0);
        mode = 2'b10; E = 1'b1;
        tick();
        check("postrst_entry_y2", 64'(y2), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("postrst_y2_%0d", k), 64'(y2), 64'(4'(1) << scan_after[k]));
            check($sformatf("postrst_y0_%0d", k), 64'(y0), 64'h01);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Parametrised, registered N-to-2^N one-hot decoder with three operating modes: level-follow, single-shot pulse and auto-scan. It succeeds the team's fixed 3-to-8 combinational decoder wherever a decoded select must be glitch-free, edge-triggered, or self-sequencing, such as display digit strobes, row/column drivers and peripheral chip-selects. All outputs come from flops. No combinational path runs from any input to any output.

## Interface
Parameters:
- N, default 3: select width. Output width is 2^N. Legal range 1..6.
- DWELL, default 4: cycles each channel is held in SCAN mode. Must be ≥1.
- ACTIVE_LOW, default 0: when 1, Y is bitwise inverted, including its reset value.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: reset. Synchronous and active-high.
- A, input, N: channel select, used in LATCH and PULSE modes.
- E, input, 1: enable.
- mode, input, 2: 00 LATCH, 01 PULSE, 10 SCAN, 11 reserved.
- Y, output, 2^N: one-hot (or zero) decoded output. Polarity is set by ACTIVE_LOW.
- idx, output, N: index of the channel currently asserted on Y. Holds its last value while Y is zero.
- wrap, output, 1: one-cycle pulse in SCAN mode. High in the cycle Y first shows channel 0 after channel 2^N−1.

## Operation
- Internal state: e_q (previous E), mode_q (previous mode), cnt (dwell counter, width clog2(DWELL), min 1), sidx (scan index, N bits), Y, idx, wrap.
- Reset (rst=1 at an edge): Y=0 (all-ones if ACTIVE_LOW), idx=0, wrap=0, cnt=0, sidx=0, e_q=0, mode_q=00. Reset overrides all other inputs.
- e_q<=E and mode_q<=mode on every non-reset edge.
- Mode change (mode≠mode_q at an edge):
  - Y<=0, wrap<=0, cnt<=0, sidx<=0. idx holds.
  - Nothing else happens at that edge. An E rising edge that coincides with a mode change is consumed and produces no pulse.
- LATCH (00):
  - E=1: Y<=onehot(A), idx<=A.
  - E=0: Y<=0.
  - wrap<=0.
- PULSE (01):
  - E=1 and e_q=0: Y<=onehot(A), idx<=A.
  - Otherwise: Y<=0.
  - Holding E high yields exactly one single-cycle pulse. A new pulse requires E low for at least one edge.
- SCAN (10), E=1:
  - Y<=onehot(sidx), idx<=sidx.
  - wrap<=1 iff sidx==0 and the previous displayed channel was 2^N−1 (tracked by a one-bit "last was top" flag set when sidx advances from 2^N−1).
  - If cnt==DWELL−1: cnt<=0 and sidx<=sidx+1, wrapping modulo 2^N. Otherwise cnt<=cnt+1.
- SCAN (10), E=0: Y<=0, wrap<=0. cnt and sidx hold (pause). On resume the current channel finishes its remaining dwell.
- Reserved (11): Y<=0, wrap<=0, all other state holds. A is ignored.
- ACTIVE_LOW only inverts the Y output register value. Internal logic is unchanged.
- DWELL=1: the scan advances one channel per enabled cycle.

## Timing
- Latency is 1 cycle in every mode: inputs sampled at edge k appear on the outputs after edge k.
- SCAN from entry or reset: channel 0 appears after the first E-high edge. Every channel, including the first, is shown for exactly DWELL enabled cycles.
- With E continuously high, the scan period is 2^N·DWELL cycles. wrap is high for 1 cycle per period, starting from the second period.
- In SCAN, idx always matches the asserted Y bit. idx leads sidx's visible effect by zero cycles.
- Rst asserted mid-operation takes effect at that edge. The first post-reset output follows the first edge with rst=0.

## Test plan
- Reset: rst high for 2 cycles with E=1, A=7 → Y=8'h00, idx=0, wrap=0. With ACTIVE_LOW=1 → Y=8'hFF.
- LATCH, N=3: E=1, A=5 → Y=8'h20, idx=5 next cycle. A=0 → 8'h01. E=0 → 8'h00 with idx held at 0.
- PULSE: E high for 5 cycles with A=3 → Y=8'h08 for exactly one cycle, then 8'h00. Drop E for 1 cycle, raise it with A=6 → single 8'h40.
- SCAN, N=2, DWELL=2: E high for 18 cycles → Y sequence 1,1,2,2,4,4,8,8,1,1,2,2,4,4,8,8,1,1. wrap=1 only on the cycle of the 9th and 17th outputs.
- SCAN pause: drop E for 3 cycles after the first cycle of channel 1 → Y=0 for 3 cycles, then channel 1 for 1 more cycle, then channel 2 for 2 cycles.
- Mode change mid-scan (SCAN→LATCH→SCAN) and rst mid-scan → Y=0 at the change edge. The scan restarts at channel 0 with a full DWELL. Switching to PULSE with E already rising at the change edge produces no pulse.
